// File: rtl/seq_add_sub.sv
// Multi-cycle signed adder/subtractor that processes CHUNK bits per clock.
// Flags are registered on the final chunk and held until the next operation completes.
module seq_add_sub #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             sign
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              sub_q, sub_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_out_q, carry_out_d;
    logic              overflow_q, overflow_d;
    logic              zero_q, zero_d;
    logic              sign_q, sign_d;

    int unsigned       base;
    logic [WIDTH-1:0]  b_eff;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK:0]    chunk_sum;
    logic              msb_cin;
    logic              last;

    always_comb begin
        base      = int'(cnt_q) * CHUNK;
        b_eff     = sub_q ? ~b_q : b_q;
        a_chunk   = a_q[base +: CHUNK];
        b_chunk   = b_eff[base +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit of this chunk; only meaningful on the last chunk.
        msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
        last      = (cnt_q == CntW'(N - 1));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        sign_d      = sign_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    cnt_d   = '0;
                    carry_d = sub;
                    state_d = StRun;
                end
            end
            StRun: begin
                result_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d                 = chunk_sum[CHUNK];
                cnt_d                   = cnt_q + CntW'(1);
                if (last) begin
                    cnt_d       = '0;
                    state_d     = StDone;
                    carry_out_d = chunk_sum[CHUNK];
                    overflow_d  = msb_cin ^ chunk_sum[CHUNK];
                    zero_d      = (result_d == '0);
                    sign_d      = result_d[WIDTH-1];
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            sign_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            sign_q      <= sign_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign sign      = sign_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// Self-checking bench for seq_add_sub: directed vectors, random ops against an
// arithmetic reference model, start-hold, mid-run reset and a single-chunk instance.
module tb_seq_add_sub;

    localparam int unsigned W  = 64;
    localparam int unsigned C  = 16;
    localparam int unsigned NC = W / C;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          sub;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          overflow;
    logic          zero;
    logic          sign;

    // Single-chunk instance (N = 1)
    logic          start1;
    logic          sub1;
    logic [7:0]    a1;
    logic [7:0]    b1;
    logic          busy1;
    logic          done1;
    logic [7:0]    result1;
    logic          carry_out1;
    logic          overflow1;
    logic          zero1;
    logic          sign1;

    int checks = 0;
    int errors = 0;

    seq_add_sub #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .sign      (sign)
    );

    seq_add_sub #(.WIDTH(8), .CHUNK(8)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .sub       (sub1),
        .a         (a1),
        .b         (b1),
        .busy      (busy1),
        .done      (done1),
        .result    (result1),
        .carry_out (carry_out1),
        .overflow  (overflow1),
        .zero      (zero1),
        .sign      (sign1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    typedef struct {
        bit           sub;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [63:0]  res;
        bit           co;
        bit           ov;
        bit           z;
        bit           s;
    } vec_t;

    typedef struct packed {
        logic [63:0] res;
        logic        co;
        logic        ov;
        logic        z;
        logic        s;
    } exp_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact signed and unsigned arithmetic on widened operands.
    function automatic exp_t model(input bit s, input logic [63:0] x, input logic [63:0] y);
        exp_t        e;
        logic [64:0] uadd;
        logic [64:0] sres;
        if (s) begin
            sres = {x[63], x} - {y[63], y};
            e.co = (x >= y);
        end else begin
            sres = {x[63], x} + {y[63], y};
            uadd = {1'b0, x} + {1'b0, y};
            e.co = uadd[64];
        end
        e.res = sres[63:0];
        e.ov  = (sres[64] != sres[63]);
        e.z   = (sres[63:0] == 64'd0);
        e.s   = sres[63];
        return e;
    endfunction

    // Issues one operation from idle and returns the observed flags and latency.
    task automatic run_op(input bit s, input logic [63:0] x, input logic [63:0] y,
                          output exp_t got, output int lat);
        bit busy_ok;
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
        sub   = ~s;
        lat     = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        got.res = result;
        got.co  = carry_out;
        got.ov  = overflow;
        got.z   = zero;
        got.s   = sign;
        check("busy_during_run", {63'd0, busy_ok}, 64'd1);
        check("busy_low_in_done", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", {62'd0, done, busy}, 64'd0);
        check("result_held", result, got.res);
    endtask

    task automatic compare(input string tag, input exp_t got, input int lat, input exp_t e);
        check({tag, "_latency"}, 64'(lat), 64'(NC));
        check({tag, "_result"}, got.res, e.res);
        check({tag, "_carry_out"}, {63'd0, got.co}, {63'd0, e.co});
        check({tag, "_overflow"}, {63'd0, got.ov}, {63'd0, e.ov});
        check({tag, "_zero"}, {63'd0, got.z}, {63'd0, e.z});
        check({tag, "_sign"}, {63'd0, got.s}, {63'd0, e.s});
    endtask

    vec_t        vecs[6];
    exp_t        got;
    exp_t        e;
    int          lat;
    logic [63:0] corners[6];
    logic [63:0] x;
    logic [63:0] y;
    bit          s;
    bit          prev_busy;
    int          accepts[$];
    logic [8:0]  u9;
    logic [8:0]  s9;

    initial begin
        vecs[0] = '{0, 64'd5, 64'd3, 64'd8, 0, 0, 0, 0};
        vecs[1] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1, 0, 1, 0};
        vecs[2] = '{0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 0, 1, 0, 1};
        vecs[3] = '{1, 64'd5, 64'd5, 64'd0, 1, 0, 1, 0};
        vecs[4] = '{1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0, 0};
        vecs[5] = '{1, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 1};

        corners[0] = 64'd0;
        corners[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        corners[2] = 64'h7FFF_FFFF_FFFF_FFFF;
        corners[3] = 64'h8000_0000_0000_0000;
        corners[4] = 64'h0000_0000_FFFF_FFFF;
        corners[5] = 64'h0000_FFFF_0000_FFFF;

        rst_n  = 1'b0;
        start  = 1'b0;
        sub    = 1'b0;
        a      = '0;
        b      = '0;
        start1 = 1'b0;
        sub1   = 1'b0;
        a1     = '0;
        b1     = '0;

        // Reset state, before any clock edge
        #2;
        check("reset_result", result, 64'd0);
        check("reset_flags", {58'd0, busy, done, carry_out, overflow, zero, sign}, 64'd0);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", {58'd0, busy, done, carry_out, overflow, zero, sign}, 64'd0);
        #2;
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].sub, vecs[i].a, vecs[i].b, got, lat);
            e.res = vecs[i].res;
            e.co  = vecs[i].co;
            e.ov  = vecs[i].ov;
            e.z   = vecs[i].z;
            e.s   = vecs[i].s;
            compare($sformatf("vec%0d", i), got, lat, e);
        end

        // Random operations against the model, salted with corner operands
        for (int i = 0; i < 40; i++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if ((i % 3) == 0) x = corners[$urandom_range(0, 5)];
            if ((i % 4) == 1) y = corners[$urandom_range(0, 5)];
            if ((i % 7) == 2) y = x;
            s = 1'($urandom_range(0, 1));
            run_op(s, x, y, got, lat);
            compare($sformatf("rand%0d", i), got, lat, model(s, x, y));
        end

        // Start held high: accepts at edges 0 and 6, mid-run operand change ignored
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b0;
        a     = 64'd10;
        b     = 64'd20;
        prev_busy = busy;
        for (int e_i = 0; e_i < 12; e_i++) begin
            @(posedge clk);
            #1;
            if (busy && !prev_busy) accepts.push_back(e_i);
            prev_busy = busy;
            if (e_i == 1) begin
                a = 64'd100;
                b = 64'd7;
            end
            if (e_i == 4) check("hold_start_first_result", {63'd0, done} << 1 | 64'(result == 64'd30),
                                64'd3);
            if (e_i == 10) check("hold_start_second_result", {63'd0, done} << 1 | 64'(result == 64'd107),
                                 64'd3);
        end
        start = 1'b0;
        check("hold_start_accept_count", 64'(accepts.size()), 64'd2);
        if (accepts.size() == 2) begin
            check("hold_start_accept0", 64'(accepts[0]), 64'd0);
            check("hold_start_accept1", 64'(accepts[1]), 64'd6);
        end
        @(posedge clk);
        #1;
        check("hold_start_idle", {62'd0, busy, done}, 64'd0);

        // Reset two cycles into RUN
        @(negedge clk);
        start = 1'b1;
        a     = 64'h1234_5678_9ABC_DEF0;
        b     = 64'h0FED_CBA9_8765_4321;
        sub   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_result", result, 64'd0);
        check("midrun_reset_flags", {58'd0, busy, done, carry_out, overflow, zero, sign}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("midrun_reset_no_done", {62'd0, busy, done}, 64'd0);
        end
        #1;
        rst_n = 1'b1;
        run_op(1'b0, 64'd2, 64'd2, got, lat);
        compare("after_reset", got, lat, model(1'b0, 64'd2, 64'd2));

        // Single-chunk instance: one RUN cycle, same flag rules
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start1 = 1'b1;
            sub1   = 1'($urandom_range(0, 1));
            a1     = 8'($urandom);
            b1     = 8'($urandom);
            if (i == 0) begin a1 = 8'h7F; b1 = 8'h01; sub1 = 1'b0; end
            if (i == 1) begin a1 = 8'h80; b1 = 8'h01; sub1 = 1'b1; end
            if (i == 2) begin a1 = 8'hFF; b1 = 8'h01; sub1 = 1'b0; end
            if (sub1) begin
                s9 = {a1[7], a1} - {b1[7], b1};
                u9 = {8'd0, a1 >= b1};
            end else begin
                s9 = {a1[7], a1} + {b1[7], b1};
                u9 = {1'b0, a1} + {1'b0, b1};
                u9 = {8'd0, u9[8]};
            end
            @(posedge clk);
            #1;
            start1 = 1'b0;
            check("n1_busy", {62'd0, busy1, done1}, 64'd2);
            @(posedge clk);
            #1;
            check("n1_done", {62'd0, busy1, done1}, 64'd1);
            check("n1_result", {56'd0, result1}, {56'd0, s9[7:0]});
            check("n1_flags", {60'd0, carry_out1, overflow1, zero1, sign1},
                  {60'd0, u9[0], s9[8] != s9[7], s9[7:0] == 8'd0, s9[7]});
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
